spi_regfile_peripheral: RTL and testbench

- Parametrised successor to the SPI register peripheral.
- Oversamples `sclk`, `cs_n` and `pico` on the internal clock `iclk`, decodes framed SPI mode-0 transactions and performs burst reads and writes with address auto-increment.
- Writes go to a bank of `N_WR_REGS` writable registers; reads come from those registers or from a flattened bank of read-only chip registers.
- Sits between the chip pads and the trigger, instruction and mode consumers, replacing the latch-based register bank with flops in a single clock domain.

---
 rtl/spi_regfile_peripheral.sv | 182 ++++++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 register-file peripheral, oversampled on iclk, with burst access and address auto-increment.
// Optional status word at address 0: define SPI_REGFILE_STATUS_EN.
module spi_regfile_peripheral #(
  parameter int               DATA_W    = 8,
  parameter int               ADDR_W    = 7,
  parameter int               N_REGS    = 60,
  parameter int               N_WR_REGS = 3,
  parameter logic [DATA_W-1:0] WR_RESET = '0
) (
  input  logic                                      iclk,
  input  logic                                      rst,
  input  logic                                      sclk,
  input  logic                                      cs_n,
  input  logic                                      pico,
  input  logic [(N_REGS-1-N_WR_REGS)*DATA_W-1:0]    ro_regs,
  output logic                                      poci,
  output logic [N_WR_REGS*DATA_W-1:0]               wr_regs,
  output logic [N_WR_REGS-1:0]                      wr_strobe,
  output logic                                      busy
);

  localparam int N_RO    = N_REGS - 1 - N_WR_REGS;
  localparam int MAX_BIT = (ADDR_W > DATA_W - 1) ? ADDR_W : DATA_W - 1;
  localparam int CNT_W   = $clog2(MAX_BIT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_WAIT_CS} state_t;

  logic [2:0]          sclk_sh;
  logic [2:0]          cs_sh;
  logic [1:0]          pico_sh;
  logic                sclk_rise;
  logic                sclk_fall;
  logic                cs_q;
  logic                pico_s;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [ADDR_W-1:0]   hdr_sr;
  logic [ADDR_W-1:0]   addr;
  logic                rw;
  logic [DATA_W-2:0]   rx_sr;
  logic [DATA_W-1:0]   rx_word;
  logic [DATA_W-1:0]   tx_sr;
  logic [DATA_W-1:0]   rd_val;
  logic [N_WR_REGS-1:0] wr_hit;
`ifdef SPI_REGFILE_STATUS_EN
  logic                abort_flag;
  logic [DATA_W-2:0]   wr_count;
`endif

  // Pin synchronisers are pure data pipes; leaving them unreset keeps cs_n visible through rst.
  always_ff @(posedge iclk) begin
    sclk_sh <= {sclk_sh[1:0], sclk};
    cs_sh   <= {cs_sh[1:0], cs_n};
    pico_sh <= {pico_sh[0], pico};
  end

  assign cs_q    = cs_sh[2];
  assign pico_s  = pico_sh[1];
  assign rx_word = {rx_sr, pico_s};

  always_ff @(posedge iclk) begin
    if (rst) begin
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
    end else begin
      sclk_rise <= sclk_sh[1] & ~sclk_sh[2];
      sclk_fall <= ~sclk_sh[1] & sclk_sh[2];
    end
  end

  always_comb begin
    rd_val = '0;
    wr_hit = '0;
    for (int i = 0; i < N_WR_REGS; i++) begin
      if (addr == ADDR_W'(i + 1)) begin
        rd_val    = wr_regs[i*DATA_W +: DATA_W];
        wr_hit[i] = 1'b1;
      end
    end
    for (int i = 0; i < N_RO; i++) begin
      if (addr == ADDR_W'(i + 1 + N_WR_REGS)) rd_val = ro_regs[i*DATA_W +: DATA_W];
    end
`ifdef SPI_REGFILE_STATUS_EN
    if (addr == '0) rd_val = {wr_count, abort_flag};
`endif
  end

  // cs_n high overrides everything, so a word whose last bit coincides with cs_n rise is dropped.
  always_ff @(posedge iclk) begin
    if (rst) begin
      state     <= cs_q ? ST_IDLE : ST_WAIT_CS;
      bit_cnt   <= '0;
      hdr_sr    <= '0;
      addr      <= '0;
      rw        <= 1'b0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      poci      <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= '0;
      wr_regs   <= {N_WR_REGS{WR_RESET}};
`ifdef SPI_REGFILE_STATUS_EN
      abort_flag <= 1'b0;
      wr_count   <= '0;
`endif
    end else begin
      wr_strobe <= '0;
      if (cs_q) begin
`ifdef SPI_REGFILE_STATUS_EN
        if ((state == ST_HDR || state == ST_DATA) && bit_cnt != '0) abort_flag <= 1'b1;
`endif
        state   <= ST_IDLE;
        busy    <= 1'b0;
        poci    <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          // IDLE is only ever entered with cs_n high, so seeing it low here is the frame-start fall.
          ST_IDLE: begin
            state   <= ST_HDR;
            busy    <= 1'b1;
            bit_cnt <= '0;
          end
          ST_HDR: begin
            if (sclk_rise) begin
              if (bit_cnt == CNT_W'(ADDR_W)) begin
                rw      <= hdr_sr[ADDR_W-1];
                addr    <= {hdr_sr[ADDR_W-2:0], pico_s};
                state   <= ST_DATA;
                bit_cnt <= '0;
              end else begin
                hdr_sr  <= {hdr_sr[ADDR_W-2:0], pico_s};
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          ST_DATA: begin
            if (sclk_rise) begin
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                if (rw) begin
                  for (int i = 0; i < N_WR_REGS; i++) begin
                    if (wr_hit[i]) begin
                      wr_regs[i*DATA_W +: DATA_W] <= rx_word;
                      wr_strobe[i]                <= 1'b1;
                    end
                  end
`ifdef SPI_REGFILE_STATUS_EN
                  if (|wr_hit) wr_count <= wr_count + (DATA_W-1)'(1);
`endif
                end
                addr    <= addr + ADDR_W'(1);
                bit_cnt <= '0;
              end else begin
                rx_sr   <= {rx_sr[DATA_W-3:0], pico_s};
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
            // A fall with the bit counter at zero marks a word boundary: load the next readout value.
            if (sclk_fall) begin
              if (bit_cnt == '0) begin
                poci  <= rd_val[DATA_W-1];
                tx_sr <= {rd_val[DATA_W-2:0], 1'b0};
`ifdef SPI_REGFILE_STATUS_EN
                if (addr == '0) abort_flag <= 1'b0;
`endif
              end else begin
                poci  <= tx_sr[DATA_W-1];
                tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
              end
            end
          end
          default: begin
            state <= ST_WAIT_CS;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Self-checking bench for spi_regfile_peripheral: frame-level register model plus per-cycle output compare.
// Status-word expectations follow SPI_REGFILE_STATUS_EN when it is defined.
module tb_spi_regfile_peripheral;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int N_REGS = 60;
  localparam int N_WR   = 3;
  localparam int N_RO   = N_REGS - 1 - N_WR;
  localparam int HALF   = 8;
  localparam int QUIET  = 6;

  logic iclk = 1'b0;
  logic rst  = 1'b1;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic pico = 1'b0;
  logic [N_RO*DATA_W-1:0] ro_regs;
  logic                   poci;
  logic [N_WR*DATA_W-1:0] wr_regs;
  logic [N_WR-1:0]        wr_strobe;
  logic                   busy;

  spi_regfile_peripheral #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_REGS(N_REGS), .N_WR_REGS(N_WR), .WR_RESET(8'h00)
  ) dut (
    .iclk(iclk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .pico(pico), .ro_regs(ro_regs),
    .poci(poci), .wr_regs(wr_regs), .wr_strobe(wr_strobe), .busy(busy)
  );

  always #5 iclk = ~iclk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_change = 0;

  logic [7:0] m_wr [1:N_WR];
  logic [7:0] m_ro [N_WR+1:N_REGS-1];
  int         m_stb_exp  [N_WR];
  int         m_stb_seen [N_WR];
  logic [N_WR-1:0] prev_stb;
  logic       m_abort;
  logic [6:0] m_count;

  // Frame-level model state, advanced once per sclk rise.
  bit         f_active, f_killed, f_data;
  int         f_hcnt, f_wcnt;
  logic [7:0] f_hdr, f_rx, f_tx;
  logic       f_rw;
  logic [6:0] f_addr;

  logic [7:0] tx_words [4];
  logic [7:0] rx_words [4];
  logic [7:0] dummy;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] a);
    int ai;
    ai = int'(a);
    if (ai >= 1 && ai <= N_WR) return m_wr[ai];
    if (ai > N_WR && ai < N_REGS) return m_ro[ai];
`ifdef SPI_REGFILE_STATUS_EN
    if (ai == 0) return {m_count, m_abort};
`endif
    return 8'h00;
  endfunction

  function automatic logic [N_WR*DATA_W-1:0] model_wr_flat();
    logic [N_WR*DATA_W-1:0] v;
    for (int i = 0; i < N_WR; i++) v[i*DATA_W +: DATA_W] = m_wr[i+1];
    return v;
  endfunction

  // Compares DUT outputs with the model every cycle once pins have been stable for QUIET cycles.
  task automatic check_cycle();
    cyc++;
    check_output("strobe_single_cycle", 32'(prev_stb & wr_strobe), 32'h0);
    for (int i = 0; i < N_WR; i++) if (wr_strobe[i]) m_stb_seen[i]++;
    prev_stb = wr_strobe;
    if (cyc - last_change >= QUIET) begin
      check_output("wr_regs_vs_model", 32'(wr_regs), 32'(model_wr_flat()));
      check_output("busy_vs_model", 32'(busy), 32'(f_active && !f_killed));
      check_output("strobe_idle", 32'(wr_strobe), 32'h0);
      if (!f_active || f_killed || !f_data) check_output("poci_idle", 32'(poci), 32'h0);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(negedge iclk);
      check_cycle();
      @(posedge iclk);
      #1;
    end
  endtask

  task automatic mark();
    last_change = cyc;
  endtask

  task automatic load_word();
    f_tx = model_read(f_addr);
`ifdef SPI_REGFILE_STATUS_EN
    if (f_addr == 7'd0) m_abort = 1'b0;
`endif
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    mark();
    f_active = 1'b1; f_killed = 1'b0; f_data = 1'b0;
    f_hcnt = 0; f_wcnt = 0;
    wait_cycles(HALF);
  endtask

  task automatic end_frame();
    wait_cycles(HALF);
    cs_n = 1'b1;
    mark();
    if (f_active && !f_killed && ((!f_data && f_hcnt != 0) || (f_data && f_wcnt != 0))) m_abort = 1'b1;
    f_active = 1'b0;
    wait_cycles(HALF);
  endtask

  task automatic clk_bit(input logic b, output logic got);
    logic exp_p;
    int   ai;
    pico = b;
    wait_cycles(HALF);
    sclk = 1'b1;
    mark();
    got   = poci;
    exp_p = (f_active && !f_killed && f_data) ? f_tx[7-f_wcnt] : 1'b0;
    check_output("poci_bit", 32'(got), 32'(exp_p));
    if (f_active && !f_killed) begin
      if (!f_data) begin
        f_hdr = {f_hdr[6:0], b};
        f_hcnt++;
        if (f_hcnt == 8) begin
          f_rw = f_hdr[7]; f_addr = f_hdr[6:0]; f_data = 1'b1; f_wcnt = 0;
          load_word();
        end
      end else begin
        f_rx = {f_rx[6:0], b};
        f_wcnt++;
        if (f_wcnt == 8) begin
          ai = int'(f_addr);
          if (f_rw && ai >= 1 && ai <= N_WR) begin
            m_wr[ai] = f_rx;
            m_stb_exp[ai-1]++;
            m_count = m_count + 7'd1;
          end
          f_addr = f_addr + 7'd1;
          f_wcnt = 0;
          load_word();
        end
      end
    end
    wait_cycles(HALF);
    sclk = 1'b0;
    mark();
  endtask

  task automatic send_bits(input logic [7:0] v, input int n, output logic [7:0] got);
    logic s;
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      clk_bit(v[7-i], s);
      got = {got[6:0], s};
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] hdr, input int nw);
    start_frame();
    send_bits(hdr, 8, dummy);
    for (int w = 0; w < nw; w++) send_bits(tx_words[w], 8, rx_words[w]);
    end_frame();
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    mark();
    for (int i = 1; i <= N_WR; i++) m_wr[i] = 8'h00;
    m_abort = 1'b0; m_count = 7'd0; f_killed = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
  endtask

  task automatic check_strobes(input string name, input int e0, input int e1, input int e2);
    check_output({name, "_slot1"}, 32'(m_stb_seen[0]), 32'(e0));
    check_output({name, "_slot2"}, 32'(m_stb_seen[1]), 32'(e1));
    check_output({name, "_slot3"}, 32'(m_stb_seen[2]), 32'(e2));
    for (int i = 0; i < N_WR; i++) check_output({name, "_model"}, 32'(m_stb_seen[i]), 32'(m_stb_exp[i]));
  endtask

  initial begin
    for (int i = 1; i <= N_WR; i++) m_wr[i] = 8'h00;
    for (int i = 0; i < N_WR; i++) begin m_stb_exp[i] = 0; m_stb_seen[i] = 0; end
    prev_stb = '0; m_abort = 1'b0; m_count = 7'd0;
    f_active = 1'b0; f_killed = 1'b0; f_data = 1'b0; f_hcnt = 0; f_wcnt = 0;
    f_hdr = '0; f_rx = '0; f_tx = '0; f_rw = 1'b0; f_addr = '0;
    for (int a = N_WR + 1; a < N_REGS; a++) m_ro[a] = 8'(a * 7 + 3);
    m_ro[4] = 8'h11; m_ro[5] = 8'h22; m_ro[10] = 8'hC3;
    for (int a = N_WR + 1; a < N_REGS; a++) ro_regs[(a-N_WR-1)*DATA_W +: DATA_W] = m_ro[a];

    wait_cycles(8);
    rst = 1'b0;
    mark();
    wait_cycles(8);
    check_output("reset_wr_regs", 32'(wr_regs), 32'h0);
    check_output("reset_busy", 32'(busy), 32'h0);
    check_output("reset_poci", 32'(poci), 32'h0);
    check_output("reset_strobe", 32'(wr_strobe), 32'h0);

    $display("[TB] write burst");
    tx_words[0] = 8'hA5; tx_words[1] = 8'h3C; tx_words[2] = 8'h7E;
    apply_stimulus(8'h81, 3);
    check_output("burst_wr_regs", 32'(wr_regs), 32'h7E3CA5);
    check_output("burst_poci_w0", 32'(rx_words[0]), 32'h00);
    check_output("burst_poci_w1", 32'(rx_words[1]), 32'h00);
    check_output("burst_poci_w2", 32'(rx_words[2]), 32'h00);
    check_strobes("burst_strobes", 1, 1, 1);

    $display("[TB] read burst");
    tx_words[0] = 8'h00; tx_words[1] = 8'h00;
    apply_stimulus(8'h04, 2);
    check_output("read_addr4", 32'(rx_words[0]), 32'h11);
    check_output("read_addr5", 32'(rx_words[1]), 32'h22);

    $display("[TB] address wrap");
    tx_words[2] = 8'h00;
    apply_stimulus(8'h7F, 3);
    check_output("wrap_addr127", 32'(rx_words[0]), 32'h00);
`ifdef SPI_REGFILE_STATUS_EN
    check_output("wrap_addr0", 32'(rx_words[1]), 32'h06);
`else
    check_output("wrap_addr0", 32'(rx_words[1]), 32'h00);
`endif
    check_output("wrap_addr1", 32'(rx_words[2]), 32'hA5);

    $display("[TB] abort mid-word");
    start_frame();
    send_bits(8'h82, 8, dummy);
    send_bits(8'hFF, 5, dummy);
    end_frame();
    check_output("abort_wr_regs", 32'(wr_regs), 32'h7E3CA5);
    check_strobes("abort_strobes", 1, 1, 1);
`ifdef SPI_REGFILE_STATUS_EN
    tx_words[0] = 8'h00;
    apply_stimulus(8'h00, 1);
    check_output("abort_status", 32'(rx_words[0]), 32'h07);
`endif

    $display("[TB] read-only and out-of-range targets");
    tx_words[0] = 8'hFF;
    apply_stimulus(8'h8A, 1);
    tx_words[0] = 8'h33;
    apply_stimulus(8'hBC, 1);
    tx_words[0] = 8'h44;
    apply_stimulus(8'h80, 1);
    check_strobes("ro_strobes", 1, 1, 1);
    tx_words[0] = 8'h00;
    apply_stimulus(8'h0A, 1);
    check_output("ro_addr10", 32'(rx_words[0]), 32'hC3);
    apply_stimulus(8'h3C, 1);
    check_output("oor_addr60", 32'(rx_words[0]), 32'h00);
    check_output("ro_wr_regs", 32'(wr_regs), 32'h7E3CA5);

    $display("[TB] reset mid-frame");
    start_frame();
    send_bits(8'h81, 8, dummy);
    send_bits(8'hFF, 3, dummy);
    reset_pulse();
    wait_cycles(2);
    check_output("midrst_wr_regs", 32'(wr_regs), 32'h0);
    check_output("midrst_busy", 32'(busy), 32'h0);
    check_output("midrst_poci", 32'(poci), 32'h0);
    check_output("midrst_strobe", 32'(wr_strobe), 32'h0);
    send_bits(8'hF8, 5, dummy);
    end_frame();
    check_output("midrst_after_frame", 32'(wr_regs), 32'h0);
    tx_words[0] = 8'h5A;
    apply_stimulus(8'h81, 1);
    check_output("post_reset_write", 32'(wr_regs), 32'h00005A);
    check_strobes("post_reset_strobes", 2, 1, 1);

    wait_cycles(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
